// File: rtl/conv_pkg.sv
// Shared coordinate types and default convolution geometry
// for the per-axis input coordinate calculators.
package conv_pkg;

    localparam int DEF_ADDR_WIDTH = 8;
    localparam int DEF_STRIDE     = 1;
    localparam int DEF_PADDING    = 1;
    localparam int DEF_DILATION   = 1;

    typedef logic        [DEF_ADDR_WIDTH-1:0] coord_t;
    typedef logic signed [DEF_ADDR_WIDTH:0]   scoord_t;

endpackage

// File: rtl/input_coordinate_calc_if.sv
// Request/response bundle between the loop counters, the
// coordinate calculator and the operand fetch unit.
interface input_coordinate_calc_if
    import conv_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);

    logic                         in_valid;
    logic        [ADDR_WIDTH-1:0] output_coord;
    logic        [ADDR_WIDTH-1:0] kernel_coord;
    logic                         out_valid;
    logic signed [ADDR_WIDTH:0]   input_coord;
    logic                         in_bounds;

    modport master (
        output in_valid,
        output output_coord,
        output kernel_coord,
        input  out_valid,
        input  input_coord,
        input  in_bounds
    );

    modport slave (
        input  in_valid,
        input  output_coord,
        input  kernel_coord,
        output out_valid,
        output input_coord,
        output in_bounds
    );

endinterface

// File: rtl/input_coordinate_calc.sv
// One-axis convolution coordinate map:
// in = out*STRIDE + k*DILATION - PADDING, registered once.
module input_coordinate_calc
    import conv_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int STRIDE     = DEF_STRIDE,
    parameter int PADDING    = DEF_PADDING,
    parameter int DILATION   = DEF_DILATION,
    parameter int INPUT_SIZE = 2 ** ADDR_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input_coordinate_calc_if.slave   bus
);

    // Wide enough for an ADDR_WIDTH operand times any positive
    // 32-bit parameter, plus the sum and the sign.
    localparam int FW = ADDR_WIDTH + 34;

    localparam logic signed [FW-1:0] STRIDE_W = FW'(STRIDE);
    localparam logic signed [FW-1:0] DIL_W    = FW'(DILATION);
    localparam logic signed [FW-1:0] PAD_W    = FW'(PADDING);
    localparam logic signed [FW-1:0] SIZE_W   = FW'(INPUT_SIZE);

    generate
        if (STRIDE < 1) begin : g_bad_stride
            $error("input_coordinate_calc: STRIDE must be >= 1");
        end
        if (DILATION < 1) begin : g_bad_dilation
            $error("input_coordinate_calc: DILATION must be >= 1");
        end
        if (PADDING < 0 || PADDING >= (2 ** ADDR_WIDTH)) begin : g_bad_pad
            $error("input_coordinate_calc: PADDING out of range");
        end
    endgenerate

    logic signed [FW-1:0]     out_w;
    logic signed [FW-1:0]     k_w;
    logic signed [FW-1:0]     full;
    logic                     full_in_bounds;
    logic signed [ADDR_WIDTH:0] full_trunc;

    // Full-precision multiply-add; bounds judged before truncation.
    always_comb begin
        out_w          = FW'(bus.output_coord);
        k_w            = FW'(bus.kernel_coord);
        full           = out_w * STRIDE_W + k_w * DIL_W - PAD_W;
        full_in_bounds = !full[FW-1] && (full < SIZE_W);
        full_trunc     = full[ADDR_WIDTH:0];
    end

    // Single result register; data holds when no new request.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_valid   <= 1'b0;
            bus.input_coord <= '0;
            bus.in_bounds   <= 1'b0;
        end else begin
            bus.out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                bus.input_coord <= full_trunc;
                bus.in_bounds   <= full_in_bounds;
            end
        end
    end

endmodule

// File: tb/tb_input_coordinate_calc.sv
// Scoreboard bench: default geometry instance (a) and a
// stride/dilation 2, size 8 instance (b).
module tb_input_coordinate_calc;
    import conv_pkg::*;

    typedef struct packed {
        logic [8:0] coord;
        logic       ib;
    } exp_t;

    logic clk;
    logic rst;
    int   n_pass;
    int   n_total;
    exp_t qa[$];
    exp_t qb[$];

    input_coordinate_calc_if #(.ADDR_WIDTH(8)) ifa ();
    input_coordinate_calc_if #(.ADDR_WIDTH(8)) ifb ();

    input_coordinate_calc #(
        .ADDR_WIDTH(8),
        .STRIDE    (1),
        .PADDING   (1),
        .DILATION  (1),
        .INPUT_SIZE(256)
    ) dut_a (
        .clk(clk),
        .rst(rst),
        .bus(ifa.slave)
    );

    input_coordinate_calc #(
        .ADDR_WIDTH(8),
        .STRIDE    (2),
        .PADDING   (1),
        .DILATION  (2),
        .INPUT_SIZE(8)
    ) dut_b (
        .clk(clk),
        .rst(rst),
        .bus(ifb.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [8:0] act,
                         input logic [8:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        else
            n_pass++;
    endtask

    // Monitor for instance a: pop and compare on each output.
    always @(negedge clk) begin
        if (ifa.out_valid === 1'b1) begin
            if (qa.size() == 0) begin
                check("a_unexpected_valid", 9'd1, 9'd0);
            end else begin
                exp_t e;
                e = qa.pop_front();
                check("a_coord", ifa.input_coord, e.coord);
                check("a_in_bounds", {8'd0, ifa.in_bounds}, {8'd0, e.ib});
            end
        end
    end

    // Monitor for instance b.
    always @(negedge clk) begin
        if (ifb.out_valid === 1'b1) begin
            if (qb.size() == 0) begin
                check("b_unexpected_valid", 9'd1, 9'd0);
            end else begin
                exp_t e;
                e = qb.pop_front();
                check("b_coord", ifb.input_coord, e.coord);
                check("b_in_bounds", {8'd0, ifb.in_bounds}, {8'd0, e.ib});
            end
        end
    end

    // Vectors: {out, k, expected 9-bit coord, expected in_bounds}
    logic [7:0] va_o [7];
    logic [7:0] va_k [7];
    exp_t       va_e [7];
    logic [7:0] vb_o [3];
    logic [7:0] vb_k [3];
    exp_t       vb_e [3];

    initial begin
        n_pass  = 0;
        n_total = 0;

        va_o[0] = 8'd0;   va_k[0] = 8'd0;   va_e[0] = '{9'h1FF, 1'b0};
        va_o[1] = 8'd1;   va_k[1] = 8'd0;   va_e[1] = '{9'd0,   1'b1};
        va_o[2] = 8'd1;   va_k[2] = 8'd1;   va_e[2] = '{9'd1,   1'b1};
        va_o[3] = 8'd2;   va_k[3] = 8'd2;   va_e[3] = '{9'd3,   1'b1};
        va_o[4] = 8'd255; va_k[4] = 8'd255; va_e[4] = '{9'd509, 1'b0};
        va_o[5] = 8'd255; va_k[5] = 8'd1;   va_e[5] = '{9'd255, 1'b1};
        va_o[6] = 8'd255; va_k[6] = 8'd2;   va_e[6] = '{9'd256, 1'b0};

        vb_o[0] = 8'd3; vb_k[0] = 8'd1; vb_e[0] = '{9'd7, 1'b1};
        vb_o[1] = 8'd4; vb_k[1] = 8'd0; vb_e[1] = '{9'd7, 1'b1};
        vb_o[2] = 8'd4; vb_k[2] = 8'd1; vb_e[2] = '{9'd9, 1'b0};

        rst              = 1'b1;
        ifa.in_valid     = 1'b0;
        ifa.output_coord = '0;
        ifa.kernel_coord = '0;
        ifb.in_valid     = 1'b0;
        ifb.output_coord = '0;
        ifb.kernel_coord = '0;
        repeat (2) @(negedge clk);

        check("rst_a_valid", {8'd0, ifa.out_valid}, 9'd0);
        check("rst_a_coord", ifa.input_coord, 9'd0);
        check("rst_a_ib", {8'd0, ifa.in_bounds}, 9'd0);
        check("rst_b_valid", {8'd0, ifb.out_valid}, 9'd0);
        rst = 1'b0;

        // Back-to-back stream on both instances.
        for (int i = 0; i < 7; i++) begin
            ifa.in_valid     = 1'b1;
            ifa.output_coord = va_o[i];
            ifa.kernel_coord = va_k[i];
            qa.push_back(va_e[i]);
            if (i < 3) begin
                ifb.in_valid     = 1'b1;
                ifb.output_coord = vb_o[i];
                ifb.kernel_coord = vb_k[i];
                qb.push_back(vb_e[i]);
            end else begin
                ifb.in_valid = 1'b0;
            end
            @(negedge clk);
        end
        ifa.in_valid = 1'b0;
        ifb.in_valid = 1'b0;
        #1;
        check("a_stream_drained", 9'(qa.size()), 9'd0);
        check("b_stream_drained", 9'(qb.size()), 9'd0);

        @(negedge clk);
        check("a_idle_valid", {8'd0, ifa.out_valid}, 9'd0);
        check("a_idle_hold", ifa.input_coord, 9'd256);
        check("b_idle_hold", ifb.input_coord, 9'd9);

        // Single pulse then hold.
        ifa.in_valid     = 1'b1;
        ifa.output_coord = 8'd2;
        ifa.kernel_coord = 8'd2;
        qa.push_back('{9'd3, 1'b1});
        @(negedge clk);
        ifa.in_valid     = 1'b0;
        ifa.output_coord = 8'd0;
        ifa.kernel_coord = 8'd0;
        @(negedge clk);
        check("pulse_valid_drop", {8'd0, ifa.out_valid}, 9'd0);
        check("pulse_hold_coord", ifa.input_coord, 9'd3);
        check("pulse_hold_ib", {8'd0, ifa.in_bounds}, 9'd1);
        @(negedge clk);
        check("pulse_hold_coord2", ifa.input_coord, 9'd3);

        // Reset beats a simultaneous request.
        ifa.in_valid     = 1'b1;
        ifa.output_coord = 8'd5;
        ifa.kernel_coord = 8'd5;
        rst              = 1'b1;
        @(negedge clk);
        check("rst_win_valid", {8'd0, ifa.out_valid}, 9'd0);
        check("rst_win_coord", ifa.input_coord, 9'd0);
        check("rst_win_ib", {8'd0, ifa.in_bounds}, 9'd0);
        rst          = 1'b0;
        ifa.in_valid = 1'b0;
        repeat (2) @(negedge clk);

        check("a_final_empty", 9'(qa.size()), 9'd0);
        check("b_final_empty", 9'(qb.size()), 9'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
